// File: rtl/hazard_unit.sv
// Hazard unit for a five-stage in-order pipeline.
// Tracks the X, M and W stages in a shadow pipeline and uses it to derive
// load-use stalls, branch flushes, X-stage operand forwarding and the
// W->M store-data bypass. Two saturating counters record stall and flush cycles.
module hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rwe,
  input  logic              id_load,
  input  logic              id_store,
  input  logic              id_valid,
  input  logic              ex_branch_taken,
  output logic              stall,
  output logic              flush_fd,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              wm_bypass,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              valid;
    logic              use_rs;
    logic              use_rt;
    logic              rwe;
    logic              load;
    logic              store;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
  } entry_t;

  // With a two-cycle load, a load sitting in M still has no data to forward.
  localparam logic P_STALL_ON_M = (LOAD_LAT == 2);

  entry_t r_x, r_m, r_w;
  entry_t w_fd, w_x_next;

  logic             w_rs_hit;
  logic             w_rt_hit;
  logic             w_stall_raw;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // An entry writes a real register (r0 is hard-wired and never a producer).
  function automatic logic f_prod(entry_t e);
    return e.valid && e.rwe && (e.rd != '0);
  endfunction

  // A load whose destination matches the given source register.
  function automatic logic f_load_hit(entry_t e, logic [REG_AW-1:0] src);
    return f_prod(e) && e.load && (e.rd == src);
  endfunction

  // Operand source for X: M (non-load only) beats W, otherwise regfile.
  function automatic logic [1:0] f_fwd(logic use_src, logic [REG_AW-1:0] src,
                                       entry_t m, entry_t w);
    if (use_src && f_prod(m) && !m.load && (m.rd == src)) return 2'd1;
    if (use_src && f_prod(w) && (w.rd == src))            return 2'd2;
    return 2'd0;
  endfunction

  // Gather the F/D instruction fields into one shadow entry.
  always_comb begin
    w_fd        = '0;
    w_fd.valid  = id_valid;
    w_fd.use_rs = id_use_rs;
    w_fd.use_rt = id_use_rt;
    w_fd.rwe    = id_rwe;
    w_fd.load   = id_load;
    w_fd.store  = id_store;
    w_fd.rs     = id_rs;
    w_fd.rt     = id_rt;
    w_fd.rd     = id_rd;
  end

  // Store data (rt) is bypassed in M, so a store never stalls on its rt.
  assign w_rs_hit    = id_use_rs &&
                       (f_load_hit(r_x, id_rs) || (P_STALL_ON_M && f_load_hit(r_m, id_rs)));
  assign w_rt_hit    = id_use_rt && !id_store &&
                       (f_load_hit(r_x, id_rt) || (P_STALL_ON_M && f_load_hit(r_m, id_rt)));
  assign w_stall_raw = id_valid && (w_rs_hit || w_rt_hit);

  // A taken branch squashes F/D anyway, so it overrides the stall.
  assign flush_fd  = ex_branch_taken;
  assign stall     = w_stall_raw && !ex_branch_taken;
  assign fwd_a_sel = f_fwd(r_x.use_rs, r_x.rs, r_m, r_w);
  assign fwd_b_sel = f_fwd(r_x.use_rt, r_x.rt, r_m, r_w);
  assign wm_bypass = r_m.store && f_prod(r_w) && (r_w.rd == r_m.rt);
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

  // Next X entry: the F/D instruction if it advances, otherwise a bubble.
  always_comb begin
    w_x_next = '0;
    if (id_valid && !stall && !flush_fd) begin
      w_x_next = w_fd;
    end
  end

  // Advance the shadow pipeline every cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_m <= '0;
      r_w <= '0;
    end else begin
      r_w <= r_m;
      r_m <= r_x;
      r_x <= w_x_next;
    end
  end

  // Count stall cycles, holding at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Count flush cycles, holding at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flush_cnt <= '0;
    end else if (flush_fd && (r_flush_cnt != '1)) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // W keeps its full record for debug visibility; only rd/valid/rwe feed logic.
  logic w_unused_w;
  assign w_unused_w = ^{r_w.rs, r_w.rt, r_w.use_rs, r_w.use_rt, r_w.load, r_w.store};

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: one instance with single-cycle loads and one with
// two-cycle loads, each compared every cycle against a behavioural model,
// plus directed instruction sequences with hand-derived expectations.
module tb_hazard_unit;

  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [AW-1:0] id_rs [2];
  logic [AW-1:0] id_rt [2];
  logic [AW-1:0] id_rd [2];
  logic          id_use_rs [2];
  logic          id_use_rt [2];
  logic          id_rwe [2];
  logic          id_load [2];
  logic          id_store [2];
  logic          id_valid [2];
  logic          ex_br [2];

  logic          stall [2];
  logic          flush_fd [2];
  logic [1:0]    fwd_a [2];
  logic [1:0]    fwd_b [2];
  logic          wm [2];
  logic [CW-1:0] scnt_o [2];
  logic [CW-1:0] fcnt_o [2];

  hazard_unit #(.REG_AW(AW), .LOAD_LAT(1), .CNT_W(CW)) u_dut1 (
    .clock(clock), .reset(reset),
    .id_rs(id_rs[0]), .id_rt(id_rt[0]), .id_use_rs(id_use_rs[0]), .id_use_rt(id_use_rt[0]),
    .id_rd(id_rd[0]), .id_rwe(id_rwe[0]), .id_load(id_load[0]), .id_store(id_store[0]),
    .id_valid(id_valid[0]), .ex_branch_taken(ex_br[0]),
    .stall(stall[0]), .flush_fd(flush_fd[0]), .fwd_a_sel(fwd_a[0]), .fwd_b_sel(fwd_b[0]),
    .wm_bypass(wm[0]), .stall_cnt(scnt_o[0]), .flush_cnt(fcnt_o[0])
  );

  hazard_unit #(.REG_AW(AW), .LOAD_LAT(2), .CNT_W(CW)) u_dut2 (
    .clock(clock), .reset(reset),
    .id_rs(id_rs[1]), .id_rt(id_rt[1]), .id_use_rs(id_use_rs[1]), .id_use_rt(id_use_rt[1]),
    .id_rd(id_rd[1]), .id_rwe(id_rwe[1]), .id_load(id_load[1]), .id_store(id_store[1]),
    .id_valid(id_valid[1]), .ex_branch_taken(ex_br[1]),
    .stall(stall[1]), .flush_fd(flush_fd[1]), .fwd_a_sel(fwd_a[1]), .fwd_b_sel(fwd_b[1]),
    .wm_bypass(wm[1]), .stall_cnt(scnt_o[1]), .flush_cnt(fcnt_o[1])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit v, urs, urt, rwe, ld, st;
    int rs, rt, rd;
  } ent_t;

  // pipe[k][0]=X, [1]=M, [2]=W
  ent_t pipe [2][3];
  int   m_scnt [2];
  int   m_fcnt [2];
  int   lat_q [2] = '{1, 2};

  function automatic ent_t bubble();
    ent_t e;
    e.v = 0; e.urs = 0; e.urt = 0; e.rwe = 0; e.ld = 0; e.st = 0;
    e.rs = 0; e.rt = 0; e.rd = 0;
    return e;
  endfunction

  function automatic ent_t fd_ent(int k);
    ent_t e;
    e.v = id_valid[k]; e.urs = id_use_rs[k]; e.urt = id_use_rt[k];
    e.rwe = id_rwe[k]; e.ld = id_load[k]; e.st = id_store[k];
    e.rs = int'(id_rs[k]); e.rt = int'(id_rt[k]); e.rd = int'(id_rd[k]);
    return e;
  endfunction

  function automatic bit writes_reg(ent_t e);
    return e.v && e.rwe && (e.rd != 0);
  endfunction

  // A consumer must wait while any load still in flight (within LAT stages) targets one of its sources.
  function automatic bit exp_stall(int k);
    ent_t f = fd_ent(k);
    bit hit = 0;
    if (ex_br[k] || !f.v) return 0;
    for (int s = 0; s < lat_q[k]; s++) begin
      ent_t e = pipe[k][s];
      if (writes_reg(e) && e.ld &&
          ((f.urs && e.rd == f.rs) || (f.urt && !f.st && e.rd == f.rt)))
        hit = 1;
    end
    return hit;
  endfunction

  function automatic int exp_fwd(int k, bit use_src, int src);
    ent_t m = pipe[k][1];
    ent_t w = pipe[k][2];
    if (!use_src) return 0;
    if (writes_reg(m) && !m.ld && m.rd == src) return 1;
    if (writes_reg(w) && w.rd == src) return 2;
    return 0;
  endfunction

  function automatic int exp_wm(int k);
    ent_t m = pipe[k][1];
    ent_t w = pipe[k][2];
    return (m.st && writes_reg(w) && w.rd == m.rt) ? 1 : 0;
  endfunction

  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        pipe[k][0] <= bubble();
        pipe[k][1] <= bubble();
        pipe[k][2] <= bubble();
        m_scnt[k]  <= 0;
        m_fcnt[k]  <= 0;
      end else begin
        pipe[k][2] <= pipe[k][1];
        pipe[k][1] <= pipe[k][0];
        pipe[k][0] <= (id_valid[k] && !exp_stall(k) && !ex_br[k]) ? fd_ent(k) : bubble();
        if (exp_stall(k) && m_scnt[k] < CMAX) m_scnt[k] <= m_scnt[k] + 1;
        if (ex_br[k] && m_fcnt[k] < CMAX)     m_fcnt[k] <= m_fcnt[k] + 1;
      end
    end
  end

  bit chk_en = 0;

  always @(negedge clock) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d stall", k), int'(stall[k]), int'(exp_stall(k)));
        chk($sformatf("u%0d flush_fd", k), int'(flush_fd[k]), int'(ex_br[k]));
        chk($sformatf("u%0d fwd_a_sel", k), int'(fwd_a[k]), exp_fwd(k, pipe[k][0].urs, pipe[k][0].rs));
        chk($sformatf("u%0d fwd_b_sel", k), int'(fwd_b[k]), exp_fwd(k, pipe[k][0].urt, pipe[k][0].rt));
        chk($sformatf("u%0d wm_bypass", k), int'(wm[k]), exp_wm(k));
        chk($sformatf("u%0d stall_cnt", k), int'(scnt_o[k]), m_scnt[k]);
        chk($sformatf("u%0d flush_cnt", k), int'(fcnt_o[k]), m_fcnt[k]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_fd(input int k, input bit v, input int rs, input int rt, input bit urs,
                        input bit urt, input int rd, input bit rwe, input bit ld, input bit st);
    id_valid[k] = v; id_rs[k] = AW'(rs); id_rt[k] = AW'(rt);
    id_use_rs[k] = urs; id_use_rt[k] = urt; id_rd[k] = AW'(rd);
    id_rwe[k] = rwe; id_load[k] = ld; id_store[k] = st;
  endtask

  task automatic idle(input int k);
    set_fd(k, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic lw(input int k, input int rd, input int base);
    set_fd(k, 1, base, 0, 1, 0, rd, 1, 1, 0);
  endtask

  task automatic alu(input int k, input int rd, input int rs, input int rt);
    set_fd(k, 1, rs, rt, 1, 1, rd, 1, 0, 0);
  endtask

  task automatic sw(input int k, input int data, input int base);
    set_fd(k, 1, base, data, 1, 1, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    idle(0); idle(1); ex_br[0] = 0; ex_br[1] = 0;
    reset = 1;
    tick();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idle(0); idle(1); ex_br[0] = 0; ex_br[1] = 0;
    chk_en = 1;

    // reset state: everything quiet, flush follows the branch input, no counting
    tick();
    ex_br[0] = 1;
    #2;
    chk("rst flush_fd", int'(flush_fd[0]), 1);
    chk("rst stall", int'(stall[0]), 0);
    chk("rst fwd_a", int'(fwd_a[0]), 0);
    chk("rst wm", int'(wm[0]), 0);
    tick();
    chk("rst flush_cnt held", int'(fcnt_o[0]), 0);
    ex_br[0] = 0;
    reset = 0;

    // single-cycle load: LW r8 ; ADD r9,r8,r8
    do_reset();
    lw(0, 8, 1);
    tick();
    alu(0, 9, 8, 8);
    #2 chk("lat1 stall c1", int'(stall[0]), 1);
    tick();
    #2 chk("lat1 stall c2", int'(stall[0]), 0);
    tick();
    idle(0);
    #2;
    chk("lat1 fwd_a", int'(fwd_a[0]), 2);
    chk("lat1 fwd_b", int'(fwd_b[0]), 2);
    chk("lat1 stall_cnt", int'(scnt_o[0]), 1);

    // two-cycle load: same sequence stalls twice
    do_reset();
    lw(1, 8, 1);
    tick();
    alu(1, 9, 8, 8);
    #2 chk("lat2 stall c1", int'(stall[1]), 1);
    tick();
    #2 chk("lat2 stall c2", int'(stall[1]), 1);
    tick();
    #2 chk("lat2 stall c3", int'(stall[1]), 0);
    chk("lat2 stall_cnt", int'(scnt_o[1]), 2);
    tick();
    idle(1);

    // ALU chain: ADD r3 ; SUB r4,r3,r3 ; OR r5,r3,r4
    do_reset();
    alu(0, 3, 1, 2);
    tick();
    alu(0, 4, 3, 3);
    tick();
    alu(0, 5, 3, 4);
    #2;
    chk("chain stall", int'(stall[0]), 0);
    chk("chain sub fwd_a", int'(fwd_a[0]), 1);
    chk("chain sub fwd_b", int'(fwd_b[0]), 1);
    tick();
    idle(0);
    #2;
    chk("chain or fwd_a", int'(fwd_a[0]), 2);
    chk("chain or fwd_b", int'(fwd_b[0]), 1);

    // r0 never forwards; load feeding store data uses the W->M bypass
    do_reset();
    alu(0, 0, 1, 2);
    tick();
    alu(0, 6, 0, 0);
    #2 chk("r0 stall", int'(stall[0]), 0);
    tick();
    idle(0);
    #2;
    chk("r0 fwd_a", int'(fwd_a[0]), 0);
    chk("r0 fwd_b", int'(fwd_b[0]), 0);
    lw(0, 7, 1);
    tick();
    sw(0, 7, 9);
    #2 chk("sw no stall", int'(stall[0]), 0);
    tick();
    idle(0);
    tick();
    #2 chk("sw wm_bypass", int'(wm[0]), 1);

    // two-cycle load, BEQ taken while load in M: flush beats the stall
    do_reset();
    lw(1, 8, 1);
    tick();
    set_fd(1, 1, 1, 2, 1, 1, 0, 0, 0, 0);
    tick();
    alu(1, 9, 8, 8);
    ex_br[1] = 1;
    #2;
    chk("br flush_fd", int'(flush_fd[1]), 1);
    chk("br stall", int'(stall[1]), 0);
    tick();
    ex_br[1] = 0;
    idle(1);
    #2;
    chk("br flush_cnt", int'(fcnt_o[1]), 1);
    chk("br stall_cnt", int'(scnt_o[1]), 0);

    // saturation: LW r8,0(r8) repeated stalls every other cycle -> 19 stalls in 38 cycles
    do_reset();
    lw(0, 8, 8);
    for (int i = 0; i < 38; i++) tick();
    #2 chk("sat stall_cnt", int'(scnt_o[0]), CMAX);
    tick();
    #2 chk("sat stall on", int'(stall[0]), 1);
    reset = 1;
    #1;
    chk("rst mid stall", int'(stall[0]), 0);
    chk("rst mid stall_cnt", int'(scnt_o[0]), 0);
    chk("rst mid flush_cnt", int'(fcnt_o[0]), 0);
    tick();
    reset = 0;
    idle(0);

    // randomized traffic on both instances
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        bit st = ($urandom_range(0, 3) == 0);
        set_fd(k, $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
               st ? 1'b0 : ($urandom_range(0, 3) != 0), st ? 1'b0 : ($urandom_range(0, 2) == 0), st);
        ex_br[k] = ($urandom_range(0, 7) == 0);
      end
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end

    reset = 0;
    idle(0); idle(1); ex_br[0] = 0; ex_br[1] = 0;
    tick();
    tick();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter LOAD_LAT, default 1, load-use bubbles; legal values 1 or 2.
REQ-003 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-004 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports id_rs, id_rt  in  REG_AW each  source registers of the F/D instruction.
REQ-007 SHALL have ports id_use_rs, id_use_rt  in  1 each  F/D instruction reads that source.
REQ-008 SHALL have ports id_rd  in  REG_AW, id_rwe  in  1, id_load  in  1, id_store  in  1  for the F/D instruction: destination, writes register, is load (LW/LB), is store (SW/SB).
REQ-009 SHALL have port id_valid  in  1  F/D holds a real instruction.
REQ-010 SHALL have port ex_branch_taken  in  1  branch or jump resolved taken in X.
REQ-011 SHALL have port stall  out  1  hold PC and F/D; insert a bubble into D/X.
REQ-012 SHALL have port flush_fd  out  1  squash F/D; insert a bubble into D/X.
REQ-013 SHALL have ports fwd_a_sel, fwd_b_sel  out  2 each  X-stage operand source: 0 regfile, 1 M (ALU result), 2 W (writeback data).
REQ-014 SHALL have port wm_bypass  out  1  M-stage store data taken from W.
REQ-015 SHALL have ports stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-016 SHALL keep a shadow pipeline of X, M and W entries; each entry holds valid, rs, rt, use_rs, use_rt, rd, rwe, load, store.
REQ-017 Every cycle: W<=M and M<=X; X<=F/D fields when id_valid=1 and neither stall nor flush_fd; otherwise X<=bubble with valid=0 and all flags 0.
REQ-018 An entry SHALL be a hazard producer only when valid=1, rwe=1 and rd!=0; register 0 is never forwarded and never stalls.
REQ-019 stall SHALL be combinational: id_valid and an F/D source in use matches rd of a producing load in X, or in M when LOAD_LAT=2.
REQ-020 The rt match SHALL be ignored for the stall check when id_store=1; store data is covered by wm_bypass.
REQ-021 flush_fd SHALL equal ex_branch_taken; when both conditions hold, flush_fd=1 and stall=0 (flush wins).
REQ-022 fwd_a_sel SHALL be 1 when X.use_rs and M is a non-load producer with M.rd==X.rs; else 2 when W is a producer with W.rd==X.rs; else 0. M has priority over W.
REQ-023 fwd_b_sel SHALL follow REQ-022 using X.rt and X.use_rt.
REQ-024 Loads in M SHALL never select source 1; their data is forwarded only from W.
REQ-025 wm_bypass SHALL be 1 when M.store=1, W is a producer and W.rd==M.rt.
REQ-026 Latency: stall, flush_fd, fwd_*_sel and wm_bypass are combinational from current inputs and shadow state, with zero cycle delay.
REQ-027 stall_cnt SHALL increment on each cycle with stall=1; flush_cnt SHALL increment on each cycle with flush_fd=1. Both saturate at all-ones and do not wrap.
REQ-028 A load in X followed by a dependent consumer SHALL produce exactly LOAD_LAT consecutive stall cycles, then forwarding select 2 for the consumer in X.

Reset
REQ-029 While reset=1, all shadow entries SHALL be bubbles and both counters 0; outputs are therefore stall=0, fwd_a_sel=0, fwd_b_sel=0, wm_bypass=0, and flush_fd follows ex_branch_taken.
REQ-030 Reset asserted mid-stall SHALL deassert stall in the same cycle; no counter increments while reset=1.

Verification
REQ-031 LOAD_LAT=1: LW r8 then ADD r9,r8,r8 -> stall=1 for 1 cycle, stall_cnt=1, then fwd_a_sel=fwd_b_sel=2 when ADD is in X.
REQ-032 LOAD_LAT=2: same sequence -> stall=1 for 2 consecutive cycles, stall_cnt=2, then fwd selects 2.
REQ-033 ADD r3,.. then SUB r4,r3,r3 then OR r5,r3,r4 -> SUB sees fwd_a_sel=fwd_b_sel=1; OR sees fwd_a_sel=2, fwd_b_sel=1; no stall.
REQ-034 ADD r0,r1,r2 then ADD r6,r0,r0 -> fwd selects 0, stall 0; LW r7 then SW r7,0(r9) -> no stall, wm_bypass=1 with the SW in M.
REQ-035 LOAD_LAT=2: LW r8, BEQ, ADD r9,r8 with the branch taken while the load is in M -> flush_fd=1, stall=0, flush_cnt=1, stall_cnt=0.
REQ-036 Saturation and reset: force 2^CNT_W+3 stall cycles -> stall_cnt holds all-ones; assert reset during a stall -> stall=0 and both counters 0 immediately.
